// File: rtl/radar_stream_pkg.sv
// Shared types and helpers for the radar sample streaming path.
package radar_stream_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int FRAME_LEN = 128;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  // Complex word for the FFT: imaginary part zero, real sample in the LSBs.
  function automatic logic [2*SAMPLE_W-1:0] pack_iq(input logic [SAMPLE_W-1:0] re);
    return {{SAMPLE_W{1'b0}}, re};
  endfunction

endpackage

// File: rtl/chirp_frame_packer_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Next pointer and occupancy; full/empty judged on registered count only.
  always_comb begin
    push     = wr_en && !full;
    pop      = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/chirp_frame_packer.sv
// Packs one chirp of ADC samples into a frame-aligned AXI-Stream for the range FFT.
module chirp_frame_packer #(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chirp_start,
  input  logic                  adc_valid,
  input  logic [DATA_W-1:0]     adc_data,
  output logic [2*DATA_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  import radar_stream_pkg::*;

  localparam int CNT_W  = $clog2(FRAME_LEN);
  localparam int FIFO_W = 2*DATA_W + 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 frame_done_q, frame_done_d;
  logic [15:0]          frame_count_q, frame_count_d;

  logic                 sample_fire, is_last, pop;
  logic [2*DATA_W-1:0]  packed_word;
  logic [FIFO_W-1:0]    head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                 fifo_full, fifo_empty;

  if (DATA_W == SAMPLE_W) begin : g_pkg_pack
    assign packed_word = pack_iq(adc_data);
  end else begin : g_local_pack
    assign packed_word = {{DATA_W{1'b0}}, adc_data};
  end

  assign sample_fire = (state_q == CAPTURE) && adc_valid;
  assign is_last     = sample_fire && (cnt_q == CNT_W'(FRAME_LEN-1));

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (sample_fire),
    .wr_data ({is_last, packed_word}),
    .rd_en   (m_axis_tready),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Empty FIFO shows zeros so the idle bus matches the reset values.
  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = fifo_empty ? '0 : head[2*DATA_W-1:0];
  assign m_axis_tlast  = !fifo_empty && head[2*DATA_W];
  assign pop           = m_axis_tvalid && m_axis_tready;

  assign overflow    = overflow_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

  // Capture FSM, sample counter and status flags next-state logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    overflow_d    = overflow_q;
    frame_done_d  = pop && m_axis_tlast;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        if (chirp_start) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        // Dropped samples still advance the counter to keep tlast frame-aligned.
        if (sample_fire) begin
          if (is_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (sample_fire && fifo_full) overflow_d = 1'b1;
    if (pop && m_axis_tlast)      frame_count_d = frame_count_q + 16'd1;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      overflow_q    <= overflow_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_chirp_frame_packer.sv
// Directed testbench for chirp_frame_packer (default parameters).
module tb_chirp_frame_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chirp_start = 1'b0;
  logic        adc_valid = 1'b0;
  logic [15:0] adc_data = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        overflow;
  logic        frame_done;
  logic [15:0] frame_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [32:0] rx_q[$];
  int          fd_cnt = 0;

  chirp_frame_packer #(
    .DATA_W     (16),
    .FRAME_LEN  (128),
    .FIFO_DEPTH (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .chirp_start   (chirp_start),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .frame_done    (frame_done),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  // Record every word the sink accepts and every frame_done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) rx_q.push_back({m_axis_tlast, m_axis_tdata});
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic cyc(input logic cs, input logic av, input logic [15:0] d, input logic r);
    chirp_start   = cs;
    adc_valid     = av;
    adc_data      = d;
    m_axis_tready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    fd_cnt = 0;
  endtask

  // Counts words in rx_q that differ from base+i with tlast only at last_idx.
  function automatic int frame_errs(input int base, input int n, input int last_idx);
    int errs = 0;
    logic [32:0] exp;
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      exp = {(i == last_idx), 16'h0000, 16'(base + i)};
      if (rx_q[i] !== exp) errs++;
    end
    return errs;
  endfunction

  typedef struct {
    logic        cs;
    logic        av;
    logic [15:0] d;
    logic        rdy;
    logic        exp_v;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int bad;
    logic rdy_t;

    tbl[0] = '{cs:1'b0, av:1'b1, d:16'd5,     rdy:1'b1, exp_v:1'b0, exp_data:32'h0,        exp_last:1'b0};
    tbl[1] = '{cs:1'b1, av:1'b0, d:16'd0,     rdy:1'b0, exp_v:1'b0, exp_data:32'h0,        exp_last:1'b0};
    tbl[2] = '{cs:1'b0, av:1'b1, d:16'd10,    rdy:1'b0, exp_v:1'b1, exp_data:32'd10,       exp_last:1'b0};
    tbl[3] = '{cs:1'b0, av:1'b1, d:16'd11,    rdy:1'b0, exp_v:1'b1, exp_data:32'd10,       exp_last:1'b0};
    tbl[4] = '{cs:1'b0, av:1'b0, d:16'd0,     rdy:1'b1, exp_v:1'b1, exp_data:32'd11,       exp_last:1'b0};
    tbl[5] = '{cs:1'b0, av:1'b0, d:16'd0,     rdy:1'b1, exp_v:1'b0, exp_data:32'h0,        exp_last:1'b0};
    tbl[6] = '{cs:1'b0, av:1'b1, d:16'hFFFF,  rdy:1'b1, exp_v:1'b1, exp_data:32'h0000FFFF, exp_last:1'b0};
    tbl[7] = '{cs:1'b0, av:1'b0, d:16'd0,     rdy:1'b1, exp_v:1'b0, exp_data:32'h0,        exp_last:1'b0};

    // Reset values while rst is held.
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_count", frame_count, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle traffic is ignored without chirp_start.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 16'(i + 1), 1'b1);
      if (m_axis_tvalid !== 1'b0) bad++;
    end
    chk("idle_tvalid", bad, 0);
    chk("idle_frame_count", frame_count, 0);

    // Cycle-accurate table: start of a frame with stalls and a negative sample.
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].cs, tbl[i].av, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_tvalid", i), m_axis_tvalid, tbl[i].exp_v);
      chk($sformatf("tbl%0d_tdata", i),  m_axis_tdata,  tbl[i].exp_data);
      chk($sformatf("tbl%0d_tlast", i),  m_axis_tlast,  tbl[i].exp_last);
    end

    // Finish that frame: samples 3..127.
    clear_rx();
    for (int k = 3; k < 128; k++) cyc(1'b0, 1'b1, 16'(k), 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 16'd0, 1'b1);
    chk("tail_size", rx_q.size(), 125);
    chk("tail_words", frame_errs(3, 125, 124), 0);
    chk("tail_frame_done", fd_cnt, 1);
    chk("tail_frame_count", frame_count, 1);
    chk("tail_overflow", overflow, 0);

    // Single clean frame, tready held high; one-cycle latency checked per sample.
    clear_rx();
    cyc(1'b1, 1'b0, 16'd0, 1'b1);
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      cyc(1'b0, 1'b1, 16'(k), 1'b1);
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(k) || m_axis_tlast !== (k == 127)) bad++;
    end
    chk("single_latency", bad, 0);
    repeat (4) cyc(1'b0, 1'b0, 16'd0, 1'b1);
    chk("single_size", rx_q.size(), 128);
    chk("single_words", frame_errs(0, 128, 127), 0);
    chk("single_frame_done", fd_cnt, 1);
    chk("single_frame_count", frame_count, 2);
    chk("single_overflow", overflow, 0);

    // Gapped input every 3rd cycle with tready toggling.
    clear_rx();
    cyc(1'b1, 1'b0, 16'd0, 1'b0);
    rdy_t = 1'b0;
    for (int k = 0; k < 128; k++) begin
      rdy_t = ~rdy_t; cyc(1'b0, 1'b0, 16'd0, rdy_t);
      rdy_t = ~rdy_t; cyc(1'b0, 1'b0, 16'd0, rdy_t);
      rdy_t = ~rdy_t; cyc(1'b0, 1'b1, 16'(1000 + k), rdy_t);
    end
    repeat (20) cyc(1'b0, 1'b0, 16'd0, 1'b1);
    chk("gap_size", rx_q.size(), 128);
    chk("gap_words", frame_errs(1000, 128, 127), 0);
    chk("gap_frame_done", fd_cnt, 1);
    chk("gap_frame_count", frame_count, 3);
    chk("gap_overflow", overflow, 0);

    // chirp_start at sample 60 and at sample 127, then a stray sample.
    clear_rx();
    cyc(1'b1, 1'b0, 16'd0, 1'b1);
    for (int k = 0; k < 128; k++) cyc((k == 60) || (k == 127), 1'b1, 16'(500 + k), 1'b1);
    cyc(1'b0, 1'b1, 16'h7777, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 16'd0, 1'b1);
    chk("bound_size", rx_q.size(), 128);
    chk("bound_words", frame_errs(500, 128, 127), 0);
    chk("bound_frame_done", fd_cnt, 1);
    chk("bound_frame_count", frame_count, 4);

    // Full backpressure: 16 words kept, sample 127 (and its tlast) dropped.
    clear_rx();
    cyc(1'b1, 1'b0, 16'd0, 1'b0);
    for (int k = 0; k < 128; k++) cyc(1'b0, 1'b1, 16'(2000 + k), 1'b0);
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    chk("bp_tvalid", m_axis_tvalid, 1);
    chk("bp_head", m_axis_tdata, 32'd2000);
    chk("bp_overflow", overflow, 1);
    repeat (30) cyc(1'b0, 1'b0, 16'd0, 1'b1);
    chk("bp_size", rx_q.size(), 16);
    chk("bp_words", frame_errs(2000, 16, -1), 0);
    chk("bp_frame_done", fd_cnt, 0);
    chk("bp_frame_count", frame_count, 4);
    chk("bp_tvalid_after", m_axis_tvalid, 0);
    chk("bp_overflow_sticky", overflow, 1);

    // Reset mid-frame with 5 words queued.
    clear_rx();
    cyc(1'b1, 1'b0, 16'd0, 1'b1);
    for (int k = 0; k < 46; k++) cyc(1'b0, 1'b1, 16'(k), 1'b1);
    for (int k = 46; k < 50; k++) cyc(1'b0, 1'b1, 16'(k), 1'b0);
    chk("mid_tvalid_pre", m_axis_tvalid, 1);
    chk("mid_head_pre", m_axis_tdata, 32'd45);
    #2 rst = 1'b1;
    #1;
    chk("mid_tvalid_async", m_axis_tvalid, 0);
    chk("mid_tdata_async", m_axis_tdata, 0);
    chk("mid_overflow", overflow, 0);
    chk("mid_frame_count", frame_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 1'b0, 16'd0, 1'b1);
    chk("mid_empty", m_axis_tvalid, 0);
    clear_rx();
    cyc(1'b1, 1'b0, 16'd0, 1'b1);
    for (int k = 0; k < 128; k++) cyc(1'b0, 1'b1, 16'(3000 + k), 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 16'd0, 1'b1);
    chk("post_size", rx_q.size(), 128);
    chk("post_words", frame_errs(3000, 128, 127), 0);
    chk("post_frame_done", fd_cnt, 1);
    chk("post_frame_count", frame_count, 1);
    chk("post_overflow", overflow, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
